// File: rtl/tc_psum_drain_if.sv
// Handshake and data bundle for tc_psum_drain.
// Signals:
//   start            drain request
//   out_en/in_valid  read request to, and matrix valid from, the accumulator
//   in_data          full M x N matrix, element (r,c) at [(r*N+c)*DW_DATA +: DW_DATA]
//   m_valid/m_ready  output stream handshake
//   m_data           LANES elements of one row, lane k = column m_col+k
//   m_row/m_col      position of the current beat
//   m_last           final beat of the matrix
//   busy/done        status: not idle / one-cycle completion pulse
// Modports: master = drain block side, slave = surrounding logic side.
interface tc_psum_drain_if #(
    parameter int unsigned M       = 16,
    parameter int unsigned N       = 16,
    parameter int unsigned DW_DATA = 8,
    parameter int unsigned LANES   = 4,
    parameter int unsigned DW_POS  = 4
);
    logic                       start;
    logic                       out_en;
    logic                       in_valid;
    logic [M*N*DW_DATA-1:0]     in_data;
    logic                       m_valid;
    logic                       m_ready;
    logic [LANES*DW_DATA-1:0]   m_data;
    logic [DW_POS-1:0]          m_row;
    logic [DW_POS-1:0]          m_col;
    logic                       m_last;
    logic                       busy;
    logic                       done;

    modport master (
        input  start, in_valid, in_data, m_ready,
        output out_en, m_valid, m_data, m_row, m_col, m_last, busy, done
    );

    modport slave (
        output start, in_valid, in_data, m_ready,
        input  out_en, m_valid, m_data, m_row, m_col, m_last, busy, done
    );
endinterface

// File: rtl/tc_psum_drain.sv
// Partial-sum drain: on start, requests the accumulator matrix, snapshots it in
// one cycle, then streams it row-major as LANES-element beats with ready/valid
// backpressure.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  tc_psum_drain_if.master (request/capture, output stream, status)
module tc_psum_drain #(
    parameter int unsigned M       = 16,
    parameter int unsigned N       = 16,
    parameter int unsigned DW_DATA = 8,
    parameter int unsigned LANES   = 4,
    parameter int unsigned DW_POS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    tc_psum_drain_if.master   bus
);
    localparam int unsigned BeatW    = LANES * DW_DATA;
    localparam int unsigned NumBeats = M * N / LANES;
    localparam int unsigned BeatIdxW = (NumBeats > 1) ? $clog2(NumBeats) : 1;

    localparam logic [DW_POS-1:0] LastRow = DW_POS'(M - 1);
    localparam logic [DW_POS-1:0] LastCol = DW_POS'(N - LANES);
    localparam logic [DW_POS-1:0] ColStep = DW_POS'(LANES);

    typedef enum logic [1:0] {StIdle, StReq, StStream, StDone} state_e;

    state_e                state_q, state_d;
    logic [DW_POS-1:0]     row_q, row_d;
    logic [DW_POS-1:0]     col_q, col_d;
    // Flat beat index kept alongside row/col so the snapshot read is a plain array lookup.
    logic [BeatIdxW-1:0]   beat_q, beat_d;
    logic [BeatW-1:0]      snap_q [NumBeats];
    logic                  capture;
    logic                  last_beat;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        beat_d    = beat_q;
        capture   = 1'b0;
        last_beat = (row_q == LastRow) && (col_q == LastCol);

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StReq;
                    row_d   = '0;
                    col_d   = '0;
                    beat_d  = '0;
                end
            end
            StReq: begin
                if (bus.in_valid) begin
                    state_d = StStream;
                    capture = 1'b1;
                end
            end
            StStream: begin
                if (bus.m_ready) begin
                    if (last_beat) begin
                        state_d = StDone;
                        row_d   = '0;
                        col_d   = '0;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        if (col_q == LastCol) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + ColStep;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            beat_q  <= beat_d;
        end
    end

    // Snapshot is only written on the capture edge so later in_data changes cannot leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NumBeats); i++) begin
                snap_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < int'(NumBeats); i++) begin
                snap_q[i] <= bus.in_data[i*BeatW +: BeatW];
            end
        end
    end

    always_comb begin
        bus.out_en  = (state_q == StReq);
        bus.m_valid = (state_q == StStream);
        bus.m_last  = (state_q == StStream) && last_beat;
        bus.busy    = (state_q != StIdle);
        bus.done    = (state_q == StDone);
        bus.m_row   = row_q;
        bus.m_col   = col_q;
        // Data is zeroed outside STREAM so nothing stale is visible on an idle bus.
        bus.m_data  = (state_q == StStream) ? snap_q[beat_q] : '0;
    end
endmodule

// File: tb/tb_tc_psum_drain.sv
module tb_tc_psum_drain;
    localparam int unsigned M       = 16;
    localparam int unsigned N       = 16;
    localparam int unsigned DW_DATA = 8;
    localparam int unsigned LANES   = 4;
    localparam int unsigned DW_POS  = 4;
    localparam int unsigned BW      = LANES * DW_DATA;
    localparam int          NB      = M * N / LANES;
    localparam int          BPR     = N / LANES;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tc_psum_drain_if #(.M(M), .N(N), .DW_DATA(DW_DATA), .LANES(LANES), .DW_POS(DW_POS)) bus ();

    tc_psum_drain #(.M(M), .N(N), .DW_DATA(DW_DATA), .LANES(LANES), .DW_POS(DW_POS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Observations gathered by the drain driver.
    logic [BW-1:0] obs_data[$];
    int obs_row[$];
    int obs_col[$];
    int obs_last[$];
    int oen_cycles, first_oen, first_valid, valid_in_req, n_done, done_cyc, last_acc_cyc;
    int n_unstable, n_stalls, post_busy, timed_out, abort_mv, abort_busy;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] exp_beat(input int r, input int c);
        logic [BW-1:0] res;
        for (int k = 0; k < int'(LANES); k++) begin
            res[k*DW_DATA +: DW_DATA] = DW_DATA'(r * 16 + c + k);
        end
        return res;
    endfunction

    task automatic fill_matrix();
        for (int r = 0; r < int'(M); r++) begin
            for (int c = 0; c < int'(N); c++) begin
                bus.in_data[(r*N+c)*DW_DATA +: DW_DATA] = DW_DATA'(r * 16 + c);
            end
        end
    endtask

    // Runs one drain, recording what the DUT does; the test tasks judge it.
    task automatic drain(input int valid_delay, input bit rand_ready, input bit ff_after,
                         input int poke_beat, input bit poke_done, input int abort_beat);
        int k;
        int trail;
        bit seen_done;
        bit stalled;
        logic [BW-1:0] hd;
        logic [DW_POS-1:0] hr, hc;
        logic hl;
        obs_data.delete(); obs_row.delete(); obs_col.delete(); obs_last.delete();
        oen_cycles = 0; first_oen = -1; first_valid = -1; valid_in_req = 0; n_done = 0;
        done_cyc = -1; last_acc_cyc = -2; n_unstable = 0; n_stalls = 0; post_busy = 0;
        timed_out = 0; abort_mv = -1; abort_busy = -1;
        seen_done = 0; stalled = 0; trail = 0;
        hd = '0; hr = '0; hc = '0; hl = 1'b0;
        bus.start = 1'b1;
        tick();
        k = 1;
        while (1) begin
            bus.start = 1'b0;
            if (bus.out_en) begin
                oen_cycles++;
                if (first_oen < 0) first_oen = k;
                if (bus.m_valid) valid_in_req++;
            end
            bus.in_valid = (bus.out_en && oen_cycles > valid_delay) ? 1'b1 : 1'b0;
            if (seen_done) begin
                if (bus.busy) post_busy++;
                trail--;
                if (trail == 0) break;
            end
            if (bus.done) begin
                n_done++;
                done_cyc = k;
                if (poke_done) bus.start = 1'b1;
                if (!seen_done) begin
                    seen_done = 1;
                    trail = 3;
                end
            end
            if (bus.m_valid) begin
                if (first_valid < 0) begin
                    first_valid = k;
                    if (ff_after) bus.in_data = '1;
                end
                if (stalled && (bus.m_data !== hd || bus.m_row !== hr || bus.m_col !== hc ||
                                bus.m_last !== hl)) n_unstable++;
                if (abort_beat >= 0 && obs_data.size() == abort_beat) begin
                    bus.m_ready = 1'b0;
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    abort_mv   = int'(bus.m_valid);
                    abort_busy = int'(bus.busy);
                    for (int j = 0; j < 4; j++) begin
                        if (bus.done) n_done++;
                        tick();
                    end
                    break;
                end
                if (poke_beat >= 0 && obs_data.size() == poke_beat) bus.start = 1'b1;
                bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.m_ready) begin
                    obs_data.push_back(bus.m_data);
                    obs_row.push_back(int'(bus.m_row));
                    obs_col.push_back(int'(bus.m_col));
                    obs_last.push_back(int'(bus.m_last));
                    if (bus.m_last) last_acc_cyc = k;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    n_stalls++;
                    hd = bus.m_data; hr = bus.m_row; hc = bus.m_col; hl = bus.m_last;
                end
            end else begin
                bus.m_ready = 1'b0;
                stalled = 0;
            end
            if (k >= 3000) begin
                timed_out = 1;
                break;
            end
            tick();
            k++;
        end
        bus.in_valid = 1'b0;
        bus.m_ready  = 1'b0;
        bus.start    = 1'b0;
        fill_matrix();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.out_en !== 1'b0) begin n_fail++; $display("FAIL reset_out_en got %b want 0", bus.out_en); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", bus.m_valid); end
        n_cmp++; if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last got %b want 0", bus.m_last); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_cmp++; if (bus.m_data !== '0) begin n_fail++; $display("FAIL reset_m_data got %h want 0", bus.m_data); end
        n_cmp++; if (bus.m_row !== '0 || bus.m_col !== '0) begin
            n_fail++; $display("FAIL reset_pos got row %0d col %0d want 0 0", bus.m_row, bus.m_col);
        end
        // start held during reset must not win over rst
        bus.start = 1'b1;
        tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_overrides_start got busy %b want 0", bus.busy); end
        bus.start = 1'b0;
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.busy !== 1'b0 || bus.out_en !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_idle got busy %b out_en %b want 0 0", bus.busy, bus.out_en);
        end
    endtask

    task automatic test_basic();
        drain(0, 0, 0, -1, 0, -1);
        n_cmp++; if (timed_out !== 0) begin n_fail++; $display("FAIL basic_timeout got %0d want 0", timed_out); end
        n_cmp++; if (first_oen !== 1) begin n_fail++; $display("FAIL basic_out_en_latency got %0d want 1", first_oen); end
        n_cmp++; if (first_valid !== 2) begin n_fail++; $display("FAIL basic_valid_latency got %0d want 2", first_valid); end
        n_cmp++; if (obs_data.size() !== NB) begin n_fail++; $display("FAIL basic_beats got %0d want %0d", obs_data.size(), NB); end
        if (obs_data.size() == NB) begin
            n_cmp++; if (obs_data[0] !== 32'h03020100) begin n_fail++; $display("FAIL basic_beat0 got %h want 03020100", obs_data[0]); end
            n_cmp++; if (obs_data[5] !== 32'h17161514 || obs_row[5] !== 1 || obs_col[5] !== 4) begin
                n_fail++; $display("FAIL basic_beat5 got %h r%0d c%0d want 17161514 r1 c4", obs_data[5], obs_row[5], obs_col[5]);
            end
            n_cmp++; if (obs_row[63] !== 15 || obs_col[63] !== 12 || obs_last[63] !== 1) begin
                n_fail++; $display("FAIL basic_beat63 got r%0d c%0d last %0d want r15 c12 last 1", obs_row[63], obs_col[63], obs_last[63]);
            end
        end
        for (int i = 0; i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_beat(i / BPR, (i % BPR) * LANES) || obs_row[i] !== i / BPR ||
                obs_col[i] !== (i % BPR) * LANES || obs_last[i] !== int'(i == NB - 1)) begin
                n_fail++;
                $display("FAIL basic_seq beat %0d got %h r%0d c%0d l%0d want %h r%0d c%0d l%0d", i, obs_data[i],
                         obs_row[i], obs_col[i], obs_last[i], exp_beat(i / BPR, (i % BPR) * LANES),
                         i / BPR, (i % BPR) * LANES, int'(i == NB - 1));
            end
        end
        n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", n_done); end
        n_cmp++; if (done_cyc !== last_acc_cyc + 1) begin
            n_fail++; $display("FAIL basic_done_timing got cycle %0d want %0d", done_cyc, last_acc_cyc + 1);
        end
        n_cmp++; if (post_busy !== 0) begin n_fail++; $display("FAIL basic_idle_after_done got %0d busy cycles want 0", post_busy); end
    endtask

    task automatic test_req_wait();
        drain(5, 0, 0, -1, 0, -1);
        n_cmp++; if (oen_cycles !== 6) begin n_fail++; $display("FAIL req_wait_out_en_cycles got %0d want 6", oen_cycles); end
        n_cmp++; if (valid_in_req !== 0) begin n_fail++; $display("FAIL req_wait_valid_in_req got %0d want 0", valid_in_req); end
        n_cmp++; if (first_valid !== 7) begin n_fail++; $display("FAIL req_wait_stream_start got %0d want 7", first_valid); end
        n_cmp++; if (obs_data.size() !== NB || n_done !== 1) begin
            n_fail++; $display("FAIL req_wait_beats got %0d/%0d done want %0d/1", obs_data.size(), n_done, NB);
        end
    endtask

    task automatic test_backpressure();
        drain(0, 1, 0, -1, 0, -1);
        n_cmp++; if (timed_out !== 0) begin n_fail++; $display("FAIL bp_timeout got %0d want 0", timed_out); end
        n_cmp++; if (obs_data.size() !== NB) begin n_fail++; $display("FAIL bp_beats got %0d want %0d", obs_data.size(), NB); end
        n_cmp++; if (n_unstable !== 0) begin n_fail++; $display("FAIL bp_stable got %0d unstable want 0", n_unstable); end
        for (int i = 0; i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_beat(i / BPR, (i % BPR) * LANES) || obs_row[i] !== i / BPR ||
                obs_col[i] !== (i % BPR) * LANES || obs_last[i] !== int'(i == NB - 1)) begin
                n_fail++;
                $display("FAIL bp_seq beat %0d got %h r%0d c%0d l%0d want %h", i, obs_data[i],
                         obs_row[i], obs_col[i], obs_last[i], exp_beat(i / BPR, (i % BPR) * LANES));
            end
        end
        n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL bp_done got %0d want 1", n_done); end
    endtask

    task automatic test_snapshot();
        drain(0, 1, 1, -1, 0, -1);
        n_cmp++; if (obs_data.size() !== NB) begin n_fail++; $display("FAIL snap_beats got %0d want %0d", obs_data.size(), NB); end
        for (int i = 0; i < obs_data.size(); i++) begin
            n_cmp++;
            if (obs_data[i] !== exp_beat(i / BPR, (i % BPR) * LANES)) begin
                n_fail++;
                $display("FAIL snap_data beat %0d got %h want %h", i, obs_data[i], exp_beat(i / BPR, (i % BPR) * LANES));
            end
        end
    endtask

    task automatic test_start_ignored();
        drain(0, 0, 0, 10, 1, -1);
        n_cmp++; if (obs_data.size() !== NB) begin n_fail++; $display("FAIL ignore_beats got %0d want %0d", obs_data.size(), NB); end
        n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL ignore_done got %0d want 1", n_done); end
        n_cmp++; if (post_busy !== 0) begin n_fail++; $display("FAIL ignore_restart got %0d busy cycles want 0", post_busy); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle got busy %b want 0", bus.busy); end
    endtask

    task automatic test_abort();
        drain(0, 0, 0, -1, 0, 20);
        n_cmp++; if (abort_mv !== 0) begin n_fail++; $display("FAIL abort_m_valid got %0d want 0", abort_mv); end
        n_cmp++; if (abort_busy !== 0) begin n_fail++; $display("FAIL abort_busy got %0d want 0", abort_busy); end
        n_cmp++; if (n_done !== 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", n_done); end
        n_cmp++; if (obs_data.size() !== 20) begin n_fail++; $display("FAIL abort_beats got %0d want 20", obs_data.size()); end
        drain(0, 0, 0, -1, 0, -1);
        n_cmp++; if (obs_data.size() !== NB || n_done !== 1) begin
            n_fail++; $display("FAIL restart_beats got %0d/%0d done want %0d/1", obs_data.size(), n_done, NB);
        end
        if (obs_data.size() > 0) begin
            n_cmp++; if (obs_data[0] !== 32'h03020100 || obs_row[0] !== 0 || obs_col[0] !== 0) begin
                n_fail++; $display("FAIL restart_beat0 got %h r%0d c%0d want 03020100 r0 c0", obs_data[0], obs_row[0], obs_col[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.m_ready = 1'b0;
        bus.in_data = '0;
        fill_matrix();
        test_reset();
        test_basic();
        test_req_wait();
        test_backpressure();
        test_snapshot();
        test_start_ignored();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
